// File: rtl/writeback_regfile_if.sv
// Bundle between the SEQ Write-back/register-file block and its neighbours.
// The master side drives the retiring instruction. The slave side returns the register state.
interface writeback_regfile_if;
  logic          en;
  logic [3:0]    icode;
  logic [3:0]    rA;
  logic [3:0]    rB;
  logic          Cnd;
  logic [63:0]   valE;
  logic [63:0]   valM;
  logic [1:0]    stat_in;
  logic [1023:0] reg_file;
  logic [3:0]    dstE;
  logic [3:0]    dstM;
  logic          halted;
  logic [1:0]    stat_out;
  logic [63:0]   retired;

  modport master (
    output en, icode, rA, rB, Cnd, valE, valM, stat_in,
    input  reg_file, dstE, dstM, halted, stat_out, retired
  );

  modport slave (
    input  en, icode, rA, rB, Cnd, valE, valM, stat_in,
    output reg_file, dstE, dstM, halted, stat_out, retired
  );
endinterface

// File: rtl/writeback_regfile.sv
// SEQ Y86-64 write-back stage and architectural register file.
// It also holds the run/halt status and the count of retired instructions.
module writeback_regfile #(
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input logic                 clk,
  input logic                 rst_n,
  writeback_regfile_if.slave  wb
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  state_t        state_r;
  logic          halted_r;
  logic [1:0]    stat_r;
  logic [63:0]   retired_r;
  logic [63:0]   regs_r [15];
  logic [3:0]    dst_e_s;
  logic [3:0]    dst_m_s;
  logic          commit_s;
  logic          stop_s;
  logic [1023:0] reg_file_s;

  // E destination: cmovXX is gated by Cnd, and stack ops target %rsp
  always_comb begin
    dst_e_s = REG_NONE;
    case (wb.icode)
      4'h2:                      dst_e_s = wb.Cnd ? wb.rB : REG_NONE;
      4'h3, 4'h6:                dst_e_s = wb.rB;
      4'h8, 4'h9, 4'hA, 4'hB:    dst_e_s = REG_RSP;
      default:                   dst_e_s = REG_NONE;
    endcase
  end

  // M destination: only loads and popq write memory data
  always_comb begin
    dst_m_s = REG_NONE;
    case (wb.icode)
      4'h5, 4'hB: dst_m_s = wb.rA;
      default:    dst_m_s = REG_NONE;
    endcase
  end

  // Commit or stop qualification for the current edge
  always_comb begin
    commit_s = 1'b0;
    stop_s   = 1'b0;
    if (state_r == RUN && wb.en) begin
      commit_s = (wb.stat_in == STAT_AOK) && (wb.icode != 4'h0);
      stop_s   = !((wb.stat_in == STAT_AOK) && (wb.icode != 4'h0));
    end else begin
      commit_s = 1'b0;
      stop_s   = 1'b0;
    end
  end

  // Status FSM, register writes and the retired counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RUN;
      halted_r  <= 1'b0;
      stat_r    <= STAT_AOK;
      retired_r <= 64'h0;
      for (int i = 0; i < 15; i++) begin
        regs_r[i] <= (i == 4) ? RSP_INIT : 64'h0;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (commit_s) begin
            // valM takes priority when both ports target one register (popq %rsp)
            for (int i = 0; i < 15; i++) begin
              if (dst_m_s == 4'(i)) begin
                regs_r[i] <= wb.valM;
              end else if (dst_e_s == 4'(i)) begin
                regs_r[i] <= wb.valE;
              end else begin
                regs_r[i] <= regs_r[i];
              end
            end
            retired_r <= retired_r + 64'd1;
          end else if (stop_s) begin
            state_r  <= HALTED;
            halted_r <= 1'b1;
            stat_r   <= (wb.stat_in == STAT_AOK) ? STAT_HLT : wb.stat_in;
          end else begin
            state_r <= RUN;
          end
        end
        HALTED: begin
          state_r <= HALTED;
        end
        default: begin
          state_r  <= HALTED;
          halted_r <= 1'b1;
        end
      endcase
    end
  end

  // Flatten the register array; slot 15 is hard-wired zero
  always_comb begin
    reg_file_s = 1024'h0;
    for (int i = 0; i < 15; i++) begin
      reg_file_s[64*i +: 64] = regs_r[i];
    end
  end

  assign wb.reg_file = reg_file_s;
  assign wb.dstE     = dst_e_s;
  assign wb.dstM     = dst_m_s;
  assign wb.halted   = halted_r;
  assign wb.stat_out = stat_r;
  assign wb.retired  = retired_r;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed testbench for writeback_regfile. A spec-level model is checked on every
// negative clock edge, and literal checks pin the expected values of key scenarios.
module tb_writeback_regfile;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  writeback_regfile_if wb_bus ();

  writeback_regfile #(.RSP_INIT(64'h200)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb_bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [63:0] m_regs [16];
  bit          m_halted;
  logic [1:0]  m_stat;
  logic [63:0] m_retired;

  function automatic logic [3:0] exp_dste(input logic [3:0] ic, input logic [3:0] rb, input logic c);
    if (ic == 4'h2) return c ? rb : 4'hF;
    if (ic == 4'h3 || ic == 4'h6) return rb;
    if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] exp_dstm(input logic [3:0] ic, input logic [3:0] ra);
    return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
  endfunction

  function automatic logic [63:0] dut_reg(input int i);
    return wb_bus.reg_file[64*i +: 64];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model update: reset, then commit/halt rules from the architecture description
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 64'h0;
      m_regs[4] = 64'h200;
      m_halted  = 1'b0;
      m_stat    = 2'd0;
      m_retired = 64'h0;
    end else if (!m_halted && wb_bus.en) begin
      if (wb_bus.stat_in == 2'd0 && wb_bus.icode != 4'h0) begin
        logic [3:0] e;
        logic [3:0] m;
        e = exp_dste(wb_bus.icode, wb_bus.rB, wb_bus.Cnd);
        m = exp_dstm(wb_bus.icode, wb_bus.rA);
        if (e != 4'hF) m_regs[e] = wb_bus.valE;
        if (m != 4'hF) m_regs[m] = wb_bus.valM;
        m_retired = m_retired + 64'd1;
      end else begin
        m_halted = 1'b1;
        m_stat   = (wb_bus.stat_in == 2'd0) ? 2'd1 : wb_bus.stat_in;
      end
    end
  end

  // Compare process: every output against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 16; i++) begin
        check($sformatf("cmp_reg%0d", i), dut_reg(i), m_regs[i]);
      end
      check("cmp_dstE", 64'(wb_bus.dstE), 64'(exp_dste(wb_bus.icode, wb_bus.rB, wb_bus.Cnd)));
      check("cmp_dstM", 64'(wb_bus.dstM), 64'(exp_dstm(wb_bus.icode, wb_bus.rA)));
      check("cmp_halted", 64'(wb_bus.halted), 64'(m_halted));
      check("cmp_stat", 64'(wb_bus.stat_out), 64'(m_stat));
      check("cmp_retired", wb_bus.retired, m_retired);
    end
  end

  // Apply one retire slot, then let one rising edge pass
  task automatic step(input logic e, input logic [3:0] ic, input logic [3:0] ra,
                      input logic [3:0] rb, input logic c, input logic [63:0] ve,
                      input logic [63:0] vm, input logic [1:0] st);
    wb_bus.en      = e;
    wb_bus.icode   = ic;
    wb_bus.rA      = ra;
    wb_bus.rB      = rb;
    wb_bus.Cnd     = c;
    wb_bus.valE    = ve;
    wb_bus.valM    = vm;
    wb_bus.stat_in = st;
    @(posedge clk);
    #2;
  endtask

  initial begin
    wb_bus.en = 1'b0; wb_bus.icode = 4'h1; wb_bus.rA = 4'hF; wb_bus.rB = 4'hF;
    wb_bus.Cnd = 1'b0; wb_bus.valE = 64'h0; wb_bus.valM = 64'h0; wb_bus.stat_in = 2'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_reg4", dut_reg(4), 64'h200);
    check("rst_reg0", dut_reg(0), 64'h0);
    check("rst_reg14", dut_reg(14), 64'h0);
    check("rst_halted", 64'(wb_bus.halted), 64'h0);
    check("rst_retired", wb_bus.retired, 64'h0);
    @(posedge clk); #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    step(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h9F, 64'h0, 2'd0);
    check("irmovq_reg2", dut_reg(2), 64'h9F);
    check("irmovq_retired", wb_bus.retired, 64'd1);

    wb_bus.Cnd = 1'b0; wb_bus.icode = 4'h2; wb_bus.rB = 4'h3; #1;
    check("cmov_nc_dstE", 64'(wb_bus.dstE), 64'hF);
    step(1'b1, 4'h2, 4'hF, 4'h3, 1'b0, 64'h55, 64'h0, 2'd0);
    check("cmov_nc_reg3", dut_reg(3), 64'h0);
    step(1'b1, 4'h2, 4'hF, 4'h3, 1'b1, 64'h77, 64'h0, 2'd0);
    check("cmov_c_reg3", dut_reg(3), 64'h77);

    wb_bus.icode = 4'hB; wb_bus.rA = 4'h4; wb_bus.rB = 4'hF; #1;
    check("popq_dstE", 64'(wb_bus.dstE), 64'h4);
    check("popq_dstM", 64'(wb_bus.dstM), 64'h4);
    step(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h208, 64'hABC, 2'd0);
    check("popq_rsp", dut_reg(4), 64'hABC);

    step(1'b0, 4'h5, 4'h7, 4'h1, 1'b0, 64'h0, 64'h67A, 2'd0);
    check("stall_reg7", dut_reg(7), 64'h0);
    check("stall_retired", wb_bus.retired, 64'd4);
    step(1'b1, 4'h5, 4'h7, 4'h1, 1'b0, 64'h0, 64'h67A, 2'd0);
    check("mrmovq_reg7", dut_reg(7), 64'h67A);
    check("mrmovq_retired", wb_bus.retired, 64'd5);

    step(1'b1, 4'hC, 4'h1, 4'h1, 1'b1, 64'h11, 64'h22, 2'd0);
    check("badicode_retired", wb_bus.retired, 64'd6);
    check("badicode_reg1", dut_reg(1), 64'h0);
    step(1'b1, 4'h3, 4'hF, 4'hF, 1'b0, 64'hDEAD, 64'h0, 2'd0);
    check("regF_zero", dut_reg(15), 64'h0);
    step(1'b1, 4'hA, 4'h1, 4'hF, 1'b0, 64'h1F0, 64'h0, 2'd0);
    check("pushq_rsp", dut_reg(4), 64'h1F0);
    check("pushq_retired", wb_bus.retired, 64'd8);

    step(1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 2'd0);
    check("halt_halted", 64'(wb_bus.halted), 64'h1);
    check("halt_stat", 64'(wb_bus.stat_out), 64'h1);
    check("halt_retired", wb_bus.retired, 64'd8);
    step(1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h123, 64'h0, 2'd0);
    check("halted_reg1", dut_reg(1), 64'h0);
    check("halted_retired", wb_bus.retired, 64'd8);

    // Asynchronous reset between edges
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_reg4", dut_reg(4), 64'h200);
    check("arst_reg2", dut_reg(2), 64'h0);
    check("arst_halted", 64'(wb_bus.halted), 64'h0);
    check("arst_retired", wb_bus.retired, 64'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    step(1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'hAA, 64'h0, 2'd0);
    check("post_reg5", dut_reg(5), 64'hAA);
    step(1'b1, 4'h3, 4'hF, 4'h6, 1'b0, 64'hBB, 64'h0, 2'd2);
    check("adr_stat", 64'(wb_bus.stat_out), 64'h2);
    check("adr_reg6", dut_reg(6), 64'h0);
    check("adr_retired", wb_bus.retired, 64'd1);
    step(1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 2'd3);
    check("absorb_stat", 64'(wb_bus.stat_out), 64'h2);

    step(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 2'd0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
